// File: rtl/ifid_stage_reg.sv
// IF/ID pipeline register with load-use stall, branch flush and stall watchdog; optional STALL_PERF_CNT_EN adds perf_stall_count.
// Latency: 1 cycle fetch-to-decode; pc_write_en/idex_bubble are combinational from hazard_detected and ifid_valid.
// Backpressure: a stall holds IF/ID and drops pc_write_en, so fetch must hold its instruction while stalled.
module ifid_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int                MAX_STALL = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic              hazard_detected,
  input  logic              branch_taken,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_pc_plus4,
  output logic              ifid_valid,
  output logic [4:0]        ifid_reg_rs,
  output logic [4:0]        ifid_reg_rt,
  output logic              pc_write_en,
  output logic              idex_bubble,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0]       perf_stall_count,
`endif
  output logic              stall_timeout
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

  state_t     state;
  logic [7:0] stall_run;
  logic       stall;

  // A bubble sitting in IF/ID has no consumer to protect, so it never stalls.
  assign stall       = hazard_detected & ifid_valid;
  assign pc_write_en = ~stall;
  assign idex_bubble = stall;
  assign ifid_reg_rs = ifid_instr[25:21];
  assign ifid_reg_rt = ifid_instr[20:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (stall) begin
      ifid_instr    <= ifid_instr;
    end else if (branch_taken) begin
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= pc_plus4_in;
      ifid_valid    <= 1'b0;
    end else if (fetch_valid) begin
      ifid_instr    <= instr_in;
      ifid_pc_plus4 <= pc_plus4_in;
      ifid_valid    <= 1'b1;
    end else begin
      ifid_instr    <= NOP_INSTR;
      ifid_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      stall_run     <= 8'd0;
      stall_timeout <= 1'b0;
    end else begin
      case (state)
        RUN:     if (stall)  state <= STALL;
        STALL:   if (!stall) state <= RUN;
        default: state <= RUN;
      endcase
      if (stall) begin
        if (stall_run < MAX_STALL_C) stall_run <= stall_run + 8'd1;
        // Flag on the edge where the run count lands on the limit; sticky until reset.
        if (stall_run >= MAX_STALL_C - 8'd1) stall_timeout <= 1'b1;
      end else begin
        stall_run <= 8'd0;
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     perf_stall_count <= 32'd0;
    else if (stall) perf_stall_count <= perf_stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifid_stage_reg.sv
// Directed bench for ifid_stage_reg: reset, load-use stall, flush, stall-vs-flush priority, watchdog, bubbles.
module tb_ifid_stage_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] instr_in;
  logic [31:0] pc_plus4_in;
  logic        hazard_detected;
  logic        branch_taken;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [4:0]  ifid_reg_rs;
  logic [4:0]  ifid_reg_rt;
  logic        pc_write_en;
  logic        idex_bubble;
  logic        stall_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] LW  = 32'h8C28_0000; // lw  $8,0($1)
  localparam logic [31:0] ADD = 32'h010A_4820; // add $9,$8,$10
  localparam logic [31:0] SUB = 32'h012A_5822; // sub $11,$9,$10

  ifid_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .instr_in(instr_in),
    .pc_plus4_in(pc_plus4_in), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
    .ifid_reg_rs(ifid_reg_rs), .ifid_reg_rt(ifid_reg_rt), .pc_write_en(pc_write_en),
    .idex_bubble(idex_bubble),
`ifdef STALL_PERF_CNT_EN
    .perf_stall_count(perf_stall_count),
`endif
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: reset with random inputs
    rst_n = 1'b0;
    fetch_valid = 1'($urandom); instr_in = $urandom; pc_plus4_in = $urandom;
    hazard_detected = 1'($urandom); branch_taken = 1'($urandom);
    step(); step();
    fetch_valid = 1'($urandom); instr_in = $urandom; hazard_detected = 1'b1; branch_taken = 1'($urandom);
    #1;
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4", ifid_pc_plus4, 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_pc_we", 32'(pc_write_en), 32'h1);
    chk("rst_bubble", 32'(idex_bubble), 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    fetch_valid = 1'b0; instr_in = '0; pc_plus4_in = '0; hazard_detected = 1'b0; branch_taken = 1'b0;
    rst_n = 1'b1;

    // T2: load-use -> exactly one bubble
    fetch_valid = 1'b1; instr_in = LW; pc_plus4_in = 32'd4;
    step();
    chk("lu_lw_instr", ifid_instr, LW);
    chk("lu_lw_rt", 32'(ifid_reg_rt), 32'd8);
    instr_in = ADD; pc_plus4_in = 32'd8;
    step();
    chk("lu_add_instr", ifid_instr, ADD);
    chk("lu_add_rs", 32'(ifid_reg_rs), 32'd8);
    chk("lu_add_rt", 32'(ifid_reg_rt), 32'd10);
    instr_in = SUB; pc_plus4_in = 32'd12; hazard_detected = 1'b1;
    #1;
    chk("lu_pc_we_stall", 32'(pc_write_en), 32'h0);
    chk("lu_bubble_stall", 32'(idex_bubble), 32'h1);
    step();
    chk("lu_hold_instr", ifid_instr, ADD);
    chk("lu_hold_pc4", ifid_pc_plus4, 32'd8);
    hazard_detected = 1'b0;
    #1;
    chk("lu_pc_we_after", 32'(pc_write_en), 32'h1);
    chk("lu_bubble_after", 32'(idex_bubble), 32'h0);
    step();
    chk("lu_adv_instr", ifid_instr, SUB);
    chk("lu_adv_pc4", ifid_pc_plus4, 32'd12);

    // T3: branch flush
    instr_in = 32'h0123_4567; pc_plus4_in = 32'd16;
    step();
    chk("fl_pre_instr", ifid_instr, 32'h0123_4567);
    branch_taken = 1'b1; instr_in = 32'hDEAD_BEEF; pc_plus4_in = 32'd20;
    #1;
    chk("fl_no_bubble", 32'(idex_bubble), 32'h0);
    step();
    chk("fl_instr", ifid_instr, 32'h0);
    chk("fl_valid", 32'(ifid_valid), 32'h0);
    chk("fl_pc4", ifid_pc_plus4, 32'd20);
    chk("fl_bubble", 32'(idex_bubble), 32'h0);

    // T4: stall beats flush
    branch_taken = 1'b0; instr_in = 32'h0232_4020; pc_plus4_in = 32'd24;
    step();
    chk("sf_pre_valid", 32'(ifid_valid), 32'h1);
    hazard_detected = 1'b1; branch_taken = 1'b1; instr_in = 32'h1111_2222; pc_plus4_in = 32'd28;
    #1;
    chk("sf_bubble", 32'(idex_bubble), 32'h1);
    chk("sf_pc_we", 32'(pc_write_en), 32'h0);
    step();
    chk("sf_hold_instr", ifid_instr, 32'h0232_4020);
    chk("sf_hold_valid", 32'(ifid_valid), 32'h1);
    chk("sf_hold_pc4", ifid_pc_plus4, 32'd24);

    // T5: watchdog, starting from a fresh run count
    hazard_detected = 1'b0; branch_taken = 1'b0;
    step();
    chk("wd_valid", 32'(ifid_valid), 32'h1);
    hazard_detected = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("wd_14_edges", 32'(stall_timeout), 32'h0);
    step();
    chk("wd_15_edges", 32'(stall_timeout), 32'h1);
    hazard_detected = 1'b0;
    step(); step(); step();
    chk("wd_sticky", 32'(stall_timeout), 32'h1);
    chk("wd_pc_we", 32'(pc_write_en), 32'h1);
    hazard_detected = 1'b1;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("wd_arst_timeout", 32'(stall_timeout), 32'h0);
    chk("wd_arst_valid", 32'(ifid_valid), 32'h0);
    chk("wd_arst_bubble", 32'(idex_bubble), 32'h0);
    hazard_detected = 1'b0;
    #1;
    rst_n = 1'b1;

    // T6: bubbles and empty fetch never stall
    fetch_valid = 1'b1; instr_in = 32'h2345_6789; pc_plus4_in = 32'd40;
    step();
    fetch_valid = 1'b0; instr_in = 32'hFFFF_FFFF; pc_plus4_in = 32'd44;
    step();
    chk("nf_instr", ifid_instr, 32'h0);
    chk("nf_valid", 32'(ifid_valid), 32'h0);
    chk("nf_pc4_hold", ifid_pc_plus4, 32'd40);
    hazard_detected = 1'b1;
    #1;
    chk("nf_pc_we", 32'(pc_write_en), 32'h1);
    chk("nf_bubble", 32'(idex_bubble), 32'h0);
    fetch_valid = 1'b1; instr_in = 32'h3456_789A; pc_plus4_in = 32'd48;
    step();
    chk("nf_load_instr", ifid_instr, 32'h3456_789A);
    chk("nf_now_stall", 32'(idex_bubble), 32'h1);
`ifdef STALL_PERF_CNT_EN
    force dut.perf_stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.perf_stall_count;
    step(); step();
    chk("perf_wrap", perf_stall_count, 32'h0);
`endif
    hazard_detected = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
